// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared encodings for the PC sequencer
package seq_pkg;

    // Control-flow field of the instruction at the current PC
    typedef enum logic [1:0] {
        OP_NOP      = 2'd0,
        OP_JMP      = 2'd1,
        OP_LOOP_END = 2'd2,
        OP_HALT     = 2'd3
    } ctl_op_e;

    // Sequencer run states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } seq_state_e;

    localparam int ISSUE_CNT_W = 16;
    localparam int DRAIN_W     = 8;

endpackage

// File: rtl/loop_unit.sv
// rtl/loop_unit.sv - single-level counted loop tracker for LOOP_END instructions
module loop_unit #(
    parameter int LOOP_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              eval_i,
    input  logic [LOOP_W-1:0] count_i,
    output logic              taken_o
);

    logic              active_q;
    logic [LOOP_W-1:0] rem_q;

    // First pass consults the programmed count; later passes use the remaining back-edges
    always_comb begin
        taken_o = active_q ? (rem_q != '0) : (count_i >= LOOP_W'(2));
    end

    // Count down the back-edges of the one active loop; counts 0 and 1 never activate it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q <= 1'b0;
            rem_q    <= '0;
        end else if (clear_i) begin
            active_q <= 1'b0;
            rem_q    <= '0;
        end else if (eval_i) begin
            if (!active_q) begin
                if (count_i >= LOOP_W'(2)) begin
                    rem_q    <= count_i - LOOP_W'(2);
                    active_q <= 1'b1;
                end
            end else if (rem_q == '0) begin
                active_q <= 1'b0;
            end else begin
                rem_q <= rem_q - LOOP_W'(1);
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - run/drain sequencer steering the program counter jump port
module pc_sequencer
    import seq_pkg::*;
#(
    parameter int PC_W       = 6,
    parameter int LOOP_W     = 8,
    parameter int ENTRY      = 0,
    parameter int PIPE_DEPTH = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic                   stall_i,
    input  logic [PC_W-1:0]        pc_i,
    input  logic [1:0]             ctl_op_i,
    input  logic [PC_W-1:0]        ctl_target_i,
    input  logic [LOOP_W-1:0]      ctl_count_i,
    output logic                   pc_jmp_en_o,
    output logic [PC_W-1:0]        pc_jmp_target_o,
    output logic                   issue_valid_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic [ISSUE_CNT_W-1:0] issue_cnt_o
);

    localparam logic [PC_W-1:0]    ENTRY_PC   = PC_W'(ENTRY);
    localparam logic [PC_W-1:0]    LAST_PC    = '1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(PIPE_DEPTH > 0 ? PIPE_DEPTH - 1 : 0);

    seq_state_e             state_q;
    logic [DRAIN_W-1:0]     drain_q;
    logic                   eom_q;
    logic                   err_q;
    logic [ISSUE_CNT_W-1:0] cnt_q;

    ctl_op_e op;
    logic    run_act;
    logic    halt_now;
    logic    issue;
    logic    jumping;
    logic    eom_hit;
    logic    loop_eval;
    logic    loop_clear;
    logic    loop_taken;

    assign op         = ctl_op_e'(ctl_op_i);
    assign run_act    = (state_q == S_RUN) && !stall_i;
    // A pending end-of-memory behaves exactly like a HALT at the parked PC
    assign halt_now   = run_act && (eom_q || op == OP_HALT);
    assign issue      = run_act && !halt_now;
    assign loop_eval  = issue && (op == OP_LOOP_END);
    assign loop_clear = (state_q == S_IDLE) && start_i;
    assign jumping    = (op == OP_JMP) || ((op == OP_LOOP_END) && loop_taken);
    assign eom_hit    = issue && !jumping && (pc_i == LAST_PC);

    loop_unit #(
        .LOOP_W (LOOP_W)
    ) u_loop (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (loop_clear),
        .eval_i  (loop_eval),
        .count_i (ctl_count_i),
        .taken_o (loop_taken)
    );

    // PC steering: hold by default, park at ENTRY in IDLE, let issuing instructions advance or jump
    always_comb begin
        pc_jmp_en_o     = 1'b1;
        pc_jmp_target_o = pc_i;
        if (state_q == S_IDLE) begin
            pc_jmp_target_o = ENTRY_PC;
        end else if (issue && !eom_hit) begin
            pc_jmp_en_o     = jumping;
            pc_jmp_target_o = jumping ? ctl_target_i : pc_i;
        end
    end

    assign issue_valid_o = issue;
    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = (state_q == S_DONE);
    assign err_o         = err_q;
    assign issue_cnt_o   = cnt_q;

    // Run-state machine with drain counter, issue counter and end-of-memory tracking
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            drain_q <= '0;
            eom_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q <= S_RUN;
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                        eom_q   <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (issue && cnt_q != '1) begin
                        cnt_q <= cnt_q + ISSUE_CNT_W'(1);
                    end
                    if (eom_hit) begin
                        eom_q <= 1'b1;
                        err_q <= 1'b1;
                    end
                    if (halt_now) begin
                        state_q <= (PIPE_DEPTH == 0) ? S_DONE : S_DRAIN;
                        drain_q <= DRAIN_LAST;
                    end
                end
                S_DRAIN: begin
                    if (drain_q == '0) begin
                        state_q <= S_DONE;
                    end else begin
                        drain_q <= drain_q - DRAIN_W'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer with a program-level reference
module tb_pc_sequencer;

    localparam int PIPE_DEPTH = 3;
    localparam logic [1:0] OP_NOP  = 2'd0;
    localparam logic [1:0] OP_JMP  = 2'd1;
    localparam logic [1:0] OP_LOOP = 2'd2;
    localparam logic [1:0] OP_HALT = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stall;
    logic [5:0]  pc;
    logic [1:0]  ctl_op;
    logic [5:0]  ctl_target;
    logic [7:0]  ctl_count;
    logic        pc_jmp_en;
    logic [5:0]  pc_jmp_target;
    logic        issue_valid;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] issue_cnt;

    logic [1:0] rom_op  [64];
    logic [5:0] rom_tgt [64];
    logic [7:0] rom_cnt [64];

    int n_vec = 0;
    int n_bad = 0;

    int   exp_q[$];
    int   obs_q[$];
    logic exp_err;
    int   exp_final;
    int   ivalid_bad, cnt_bad, done_at, halt_at;
    logic [15:0] cnt_at_done;
    logic        err_at_done;
    logic [5:0]  pc_at_done;
    logic        busy_after, jen_after, done_after;
    logic [5:0]  tgt_after;

    always #5 clk = ~clk;

    pc_sequencer #(
        .PC_W       (6),
        .LOOP_W     (8),
        .ENTRY      (0),
        .PIPE_DEPTH (PIPE_DEPTH)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .start_i         (start),
        .stall_i         (stall),
        .pc_i            (pc),
        .ctl_op_i        (ctl_op),
        .ctl_target_i    (ctl_target),
        .ctl_count_i     (ctl_count),
        .pc_jmp_en_o     (pc_jmp_en),
        .pc_jmp_target_o (pc_jmp_target),
        .issue_valid_o   (issue_valid),
        .busy_o          (busy),
        .done_o          (done),
        .err_o           (err),
        .issue_cnt_o     (issue_cnt)
    );

    // Program counter environment: increments unless the jump port is enabled
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= 6'd0;
        else        pc <= pc_jmp_en ? pc_jmp_target : pc + 6'd1;
    end

    assign ctl_op     = rom_op[pc];
    assign ctl_target = rom_tgt[pc];
    assign ctl_count  = rom_cnt[pc];

    task automatic clear_rom();
        for (int p = 0; p < 64; p++) begin
            rom_op[p]  = OP_NOP;
            rom_tgt[p] = 6'd0;
            rom_cnt[p] = 8'd0;
        end
    endtask

    // Instruction-level interpretation of the ROM: which addresses issue, in order
    task automatic ref_model();
        int p, it, n;
        p = 0; it = 0; exp_q.delete(); exp_err = 1'b0; exp_final = -1;
        for (int k = 0; k < 4000; k++) begin
            if (rom_op[p] == OP_HALT) begin exp_final = p; return; end
            exp_q.push_back(p);
            if (rom_op[p] == OP_JMP) begin
                p = int'(rom_tgt[p]);
                continue;
            end
            if (rom_op[p] == OP_LOOP) begin
                n = (rom_cnt[p] < 8'd2) ? 1 : int'(rom_cnt[p]);
                it++;
                if (it < n) begin p = int'(rom_tgt[p]); continue; end
                it = 0;
            end
            if (p == 63) begin exp_err = 1'b1; exp_final = 63; return; end
            p++;
        end
    endtask

    // Start one run and record what the DUT does, cycle by cycle
    task automatic run_prog(input int stall_pct, input int dir_stall, input int max_cyc);
        int dir_left;
        bit st;
        ref_model();
        obs_q.delete();
        ivalid_bad = 0; cnt_bad = 0; done_at = -1; halt_at = -1;
        cnt_at_done = 16'hDEAD; err_at_done = 1'bx; pc_at_done = 6'h3F;
        busy_after = 1'b1; jen_after = 1'b0; tgt_after = 6'h3F; done_after = 1'b1;
        dir_left = dir_stall;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            st = ($urandom_range(0, 99) < stall_pct);
            if (dir_left > 0 && pc == 6'd2) begin st = 1'b1; dir_left--; end
            stall = st;
            start = (done_at < 0) && (stall_pct > 0) && ($urandom_range(0, 7) == 0);
            @(negedge clk);
            if (done_at >= 0) begin
                busy_after = busy; jen_after = pc_jmp_en; tgt_after = pc_jmp_target; done_after = done;
                break;
            end
            if (done) begin
                done_at = c; cnt_at_done = issue_cnt; err_at_done = err; pc_at_done = pc;
            end
            if (halt_at < 0) begin
                if (issue_cnt !== 16'(obs_q.size())) cnt_bad++;
                if (issue_valid !== (!st && obs_q.size() < exp_q.size())) ivalid_bad++;
                if (!st && obs_q.size() == exp_q.size()) halt_at = c;
                if (issue_valid) obs_q.push_back(int'(pc));
            end else if (issue_valid) begin
                ivalid_bad++;
            end
            @(posedge clk); #1;
        end
        start = 1'b0; stall = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; stall = 1'b0;
        clear_rom();
        repeat (3) @(negedge clk);
        n_vec++; if (pc_jmp_en !== 1'b1) begin n_bad++; $display("FAIL reset_jmp_en got %0b want 1", pc_jmp_en); end
        n_vec++; if (pc_jmp_target !== 6'd0) begin n_bad++; $display("FAIL reset_target got %0d want 0", pc_jmp_target); end
        n_vec++; if (issue_valid !== 1'b0) begin n_bad++; $display("FAIL reset_issue got %0b want 0", issue_valid); end
        n_vec++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL reset_flags got busy=%0b done=%0b err=%0b want 0 0 0", busy, done, err); end
        n_vec++; if (issue_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_cnt got %0d want 0", issue_cnt); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++; if (pc !== 6'd0 || busy !== 1'b0) begin n_bad++; $display("FAIL idle_park got pc=%0d busy=%0b want 0 0", pc, busy); end
    endtask

    task automatic test_straight();
        string nm = "straight";
        clear_rom();
        rom_op[4] = OP_HALT;
        run_prog(0, 0, 500);
        n_vec++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL %s issue_len got %0d want %0d", nm, obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin n_vec++; if (obs_q[i] != exp_q[i]) begin n_bad++; $display("FAIL %s issue_pc[%0d] got %0d want %0d", nm, i, obs_q[i], exp_q[i]); end end
        n_vec++; if (ivalid_bad != 0 || cnt_bad != 0) begin n_bad++; $display("FAIL %s cycle_checks got %0d/%0d bad want 0/0", nm, ivalid_bad, cnt_bad); end
        n_vec++; if (halt_at < 0 || done_at != halt_at + PIPE_DEPTH + 1) begin n_bad++; $display("FAIL %s done_cycle got %0d want %0d", nm, done_at, halt_at + PIPE_DEPTH + 1); end
        n_vec++; if (cnt_at_done !== 16'(exp_q.size()) || err_at_done !== exp_err) begin n_bad++; $display("FAIL %s cnt_err got %0d/%0b want %0d/%0b", nm, cnt_at_done, err_at_done, exp_q.size(), exp_err); end
        n_vec++; if (int'(pc_at_done) != exp_final) begin n_bad++; $display("FAIL %s final_pc got %0d want %0d", nm, pc_at_done, exp_final); end
        n_vec++; if (busy_after !== 1'b0 || jen_after !== 1'b1 || tgt_after !== 6'd0 || done_after !== 1'b0) begin n_bad++; $display("FAIL %s idle_return got busy=%0b en=%0b tgt=%0d done=%0b want 0 1 0 0", nm, busy_after, jen_after, tgt_after, done_after); end
    endtask

    task automatic test_jump();
        string nm = "jump";
        clear_rom();
        rom_op[1] = OP_JMP; rom_tgt[1] = 6'd5;
        rom_op[6] = OP_HALT;
        run_prog(0, 0, 500);
        n_vec++; if (obs_q.size() != 3) begin n_bad++; $display("FAIL %s issue_len got %0d want 3", nm, obs_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin n_vec++; if (obs_q[i] != exp_q[i]) begin n_bad++; $display("FAIL %s issue_pc[%0d] got %0d want %0d", nm, i, obs_q[i], exp_q[i]); end end
        n_vec++; if (ivalid_bad != 0 || cnt_bad != 0) begin n_bad++; $display("FAIL %s cycle_checks got %0d/%0d bad want 0/0", nm, ivalid_bad, cnt_bad); end
        n_vec++; if (halt_at < 0 || done_at != halt_at + PIPE_DEPTH + 1) begin n_bad++; $display("FAIL %s done_cycle got %0d want %0d", nm, done_at, halt_at + PIPE_DEPTH + 1); end
        n_vec++; if (cnt_at_done !== 16'd3 || err_at_done !== 1'b0) begin n_bad++; $display("FAIL %s cnt_err got %0d/%0b want 3/0", nm, cnt_at_done, err_at_done); end
        n_vec++; if (pc_at_done !== 6'd6) begin n_bad++; $display("FAIL %s final_pc got %0d want 6", nm, pc_at_done); end
    endtask

    task automatic test_loop();
        int counts[3] = '{3, 0, 1};
        int want_cnt[3] = '{10, 4, 4};
        string nm = "loop";
        foreach (counts[k]) begin
            clear_rom();
            rom_op[3] = OP_LOOP; rom_tgt[3] = 6'd1; rom_cnt[3] = 8'(counts[k]);
            rom_op[4] = OP_HALT;
            run_prog(k * 15, 0, 800);
            n_vec++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL %s[%0d] issue_len got %0d want %0d", nm, counts[k], obs_q.size(), exp_q.size()); end
            foreach (exp_q[i]) if (i < obs_q.size()) begin n_vec++; if (obs_q[i] != exp_q[i]) begin n_bad++; $display("FAIL %s[%0d] issue_pc[%0d] got %0d want %0d", nm, counts[k], i, obs_q[i], exp_q[i]); end end
            n_vec++; if (ivalid_bad != 0 || cnt_bad != 0) begin n_bad++; $display("FAIL %s[%0d] cycle_checks got %0d/%0d bad want 0/0", nm, counts[k], ivalid_bad, cnt_bad); end
            n_vec++; if (halt_at < 0 || done_at != halt_at + PIPE_DEPTH + 1) begin n_bad++; $display("FAIL %s[%0d] done_cycle got %0d want %0d", nm, counts[k], done_at, halt_at + PIPE_DEPTH + 1); end
            n_vec++; if (cnt_at_done !== 16'(want_cnt[k])) begin n_bad++; $display("FAIL %s[%0d] issue_cnt got %0d want %0d", nm, counts[k], cnt_at_done, want_cnt[k]); end
        end
    endtask

    task automatic test_stall();
        string nm = "stall";
        clear_rom();
        rom_op[2] = OP_JMP; rom_tgt[2] = 6'd6;
        rom_op[7] = OP_HALT;
        run_prog(0, 3, 500);
        n_vec++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL %s issue_len got %0d want %0d", nm, obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin n_vec++; if (obs_q[i] != exp_q[i]) begin n_bad++; $display("FAIL %s issue_pc[%0d] got %0d want %0d", nm, i, obs_q[i], exp_q[i]); end end
        n_vec++; if (ivalid_bad != 0 || cnt_bad != 0) begin n_bad++; $display("FAIL %s cycle_checks got %0d/%0d bad want 0/0", nm, ivalid_bad, cnt_bad); end
        n_vec++; if (halt_at < 0 || done_at != halt_at + PIPE_DEPTH + 1) begin n_bad++; $display("FAIL %s done_cycle got %0d want %0d", nm, done_at, halt_at + PIPE_DEPTH + 1); end
        n_vec++; if (pc_at_done !== 6'd7 || cnt_at_done !== 16'd4) begin n_bad++; $display("FAIL %s final got pc=%0d cnt=%0d want 7 4", nm, pc_at_done, cnt_at_done); end
    endtask

    task automatic test_end_of_memory();
        string nm = "end_of_memory";
        clear_rom();
        run_prog(20, 0, 2000);
        n_vec++; if (obs_q.size() != 64) begin n_bad++; $display("FAIL %s issue_len got %0d want 64", nm, obs_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin n_vec++; if (obs_q[i] != exp_q[i]) begin n_bad++; $display("FAIL %s issue_pc[%0d] got %0d want %0d", nm, i, obs_q[i], exp_q[i]); end end
        n_vec++; if (ivalid_bad != 0 || cnt_bad != 0) begin n_bad++; $display("FAIL %s cycle_checks got %0d/%0d bad want 0/0", nm, ivalid_bad, cnt_bad); end
        n_vec++; if (halt_at < 0 || done_at != halt_at + PIPE_DEPTH + 1) begin n_bad++; $display("FAIL %s done_cycle got %0d want %0d", nm, done_at, halt_at + PIPE_DEPTH + 1); end
        n_vec++; if (err_at_done !== 1'b1) begin n_bad++; $display("FAIL %s err got %0b want 1", nm, err_at_done); end
        n_vec++; if (pc_at_done !== 6'd63) begin n_bad++; $display("FAIL %s final_pc got %0d want 63", nm, pc_at_done); end
    endtask

    task automatic test_reset_mid_run();
        string nm = "reset_rerun";
        bit seen_done;
        clear_rom();
        rom_op[3] = OP_LOOP; rom_tgt[3] = 6'd1; rom_cnt[3] = 8'd3;
        rom_op[4] = OP_HALT;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_vec++; if (pc_jmp_en !== 1'b1 || pc_jmp_target !== 6'd0) begin n_bad++; $display("FAIL midreset_jmp got en=%0b tgt=%0d want 1 0", pc_jmp_en, pc_jmp_target); end
        n_vec++; if (issue_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL midreset_state got issue=%0b busy=%0b want 0 0", issue_valid, busy); end
        n_vec++; if (issue_cnt !== 16'd0 || err !== 1'b0) begin n_bad++; $display("FAIL midreset_cnt got cnt=%0d err=%0b want 0 0", issue_cnt, err); end
        seen_done = 1'b0;
        repeat (3) begin @(negedge clk); if (done !== 1'b0) seen_done = 1'b1; end
        n_vec++; if (seen_done) begin n_bad++; $display("FAIL midreset_done got 1 want 0"); end
        rst_n = 1'b1;
        run_prog(10, 0, 800);
        n_vec++; if (obs_q.size() != 10) begin n_bad++; $display("FAIL %s issue_len got %0d want 10", nm, obs_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin n_vec++; if (obs_q[i] != exp_q[i]) begin n_bad++; $display("FAIL %s issue_pc[%0d] got %0d want %0d", nm, i, obs_q[i], exp_q[i]); end end
        n_vec++; if (ivalid_bad != 0 || cnt_bad != 0) begin n_bad++; $display("FAIL %s cycle_checks got %0d/%0d bad want 0/0", nm, ivalid_bad, cnt_bad); end
        n_vec++; if (cnt_at_done !== 16'd10) begin n_bad++; $display("FAIL %s issue_cnt got %0d want 10", nm, cnt_at_done); end
    endtask

    task automatic test_random();
        int h, l, hi;
        string nm = "random";
        for (int r = 0; r < 12; r++) begin
            clear_rom();
            for (int p = 0; p < 63; p++) begin
                if ($urandom_range(0, 9) < 2) begin
                    hi = (p + 8 > 63) ? 63 : p + 8;
                    rom_op[p]  = OP_JMP;
                    rom_tgt[p] = 6'($urandom_range(p + 1, hi));
                end
            end
            l = $urandom_range(4, 62);
            rom_op[l] = OP_LOOP; rom_tgt[l] = 6'($urandom_range(l - 4, l)); rom_cnt[l] = 8'($urandom_range(0, 5));
            h = ($urandom_range(0, 9) < 7) ? int'($urandom_range(20, 63)) : -1;
            if (h >= 0) rom_op[h] = OP_HALT;
            run_prog(25, 0, 3000);
            n_vec++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL %s[%0d] issue_len got %0d want %0d", nm, r, obs_q.size(), exp_q.size()); end
            foreach (exp_q[i]) if (i < obs_q.size()) begin n_vec++; if (obs_q[i] != exp_q[i]) begin n_bad++; $display("FAIL %s[%0d] issue_pc[%0d] got %0d want %0d", nm, r, i, obs_q[i], exp_q[i]); end end
            n_vec++; if (ivalid_bad != 0 || cnt_bad != 0) begin n_bad++; $display("FAIL %s[%0d] cycle_checks got %0d/%0d bad want 0/0", nm, r, ivalid_bad, cnt_bad); end
            n_vec++; if (halt_at < 0 || done_at != halt_at + PIPE_DEPTH + 1) begin n_bad++; $display("FAIL %s[%0d] done_cycle got %0d want %0d", nm, r, done_at, halt_at + PIPE_DEPTH + 1); end
            n_vec++; if (cnt_at_done !== 16'(exp_q.size()) || err_at_done !== exp_err) begin n_bad++; $display("FAIL %s[%0d] cnt_err got %0d/%0b want %0d/%0b", nm, r, cnt_at_done, err_at_done, exp_q.size(), exp_err); end
            n_vec++; if (int'(pc_at_done) != exp_final) begin n_bad++; $display("FAIL %s[%0d] final_pc got %0d want %0d", nm, r, pc_at_done, exp_final); end
            n_vec++; if (busy_after !== 1'b0 || jen_after !== 1'b1 || tgt_after !== 6'd0 || done_after !== 1'b0) begin n_bad++; $display("FAIL %s[%0d] idle_return got busy=%0b en=%0b tgt=%0d done=%0b want 0 1 0 0", nm, r, busy_after, jen_after, tgt_after, done_after); end
        end
    endtask

    initial begin
        test_reset();
        test_straight();
        test_jump();
        test_loop();
        test_stall();
        test_end_of_memory();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Control sequencer for the `program_counter` block of the VLIW/SIMD core. It accepts a `start`/`done` handshake from the host and steers the PC through its `jmp_en`/`jmp_target` port. It decodes the control-flow field of the instruction at the current PC: fall-through, jump, counted loop, or halt. It gates issue to the datapath on stalls and drains the pipeline before reporting `done`.

## Interface
- `PC_W`, 6, width of PC and jump target
- `LOOP_W`, 8, width of the loop iteration count
- `ENTRY`, 0, program entry address
- `PIPE_DEPTH`, 3, drain cycles after HALT (0 allowed)
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  run request; sampled only in IDLE
- `stall`  in  1  datapath back-pressure; freezes sequencing
- `pc`  in  PC_W  current `program_counter` value
- `ctl_op`  in  2  control field at `pc` (combinational ROM read): 0 NOP, 1 JMP, 2 LOOP_END, 3 HALT
- `ctl_target`  in  PC_W  jump/loop target at `pc`
- `ctl_count`  in  LOOP_W  loop iteration count at `pc`
- `pc_jmp_en`  out  1  to `program_counter.jmp_en`
- `pc_jmp_target`  out  PC_W  to `program_counter.jmp_target`
- `issue_valid`  out  1  instruction at `pc` issues this cycle
- `busy`  out  1  state is not IDLE
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  sticky: PC hit the last address with a non-HALT, non-jumping instruction
- `issue_cnt`  out  16  instructions issued since last start, saturating

## Operation
- The PC increments every cycle unless `pc_jmp_en`=1. To hold the PC, drive `pc_jmp_en`=1 with `pc_jmp_target`=`pc`.
- **States:** IDLE, RUN, DRAIN, DONE.
- **IDLE:** `pc_jmp_en`=1, target=`ENTRY`, so the PC parks at ENTRY. On `start`=1, go to RUN, clear `issue_cnt` and `err`, clear the loop unit.
- **RUN, `stall`=1:** hold PC, `issue_valid`=0, loop state and counters frozen.
- **RUN, `stall`=0,** per `ctl_op`:
  - NOP: `issue_valid`=1, `pc_jmp_en`=0.
  - JMP: `issue_valid`=1, jump to `ctl_target`.
  - LOOP_END: `issue_valid`=1. The loop unit decides taken/not-taken; if taken, jump to `ctl_target`.
  - HALT: `issue_valid`=0, hold PC. Go to DRAIN, or to DONE if `PIPE_DEPTH`=0.
- **LOOP_END detail (single level, no nesting):**
  - Loop inactive: if `ctl_count`>=2, take the jump, set `rem`=`ctl_count`-2 and mark active. Otherwise fall through (body runs once).
  - Loop active: if `rem`=0, fall through and mark inactive. Otherwise `rem`-=1 and take the jump.
  - Result: the body executes exactly `ctl_count` times (count 0 or 1 behaves as 1).
- **End of memory:** in RUN, `stall`=0, `pc`=2^PC_W-1, and the instruction does not jump (NOP, or LOOP_END not taken). The instruction issues, `err` is set, and the block behaves as HALT on the next cycle. The PC must never wrap.
- **DRAIN:** hold PC, `issue_valid`=0, count `PIPE_DEPTH` cycles regardless of `stall`, then go to DONE.
- **DONE:** `done`=1 for one cycle, hold PC, then go to IDLE.
- `start` outside IDLE is ignored.
- `issue_cnt` increments on each `issue_valid` and saturates at 0xFFFF.

## Timing
- **Reset values:** state IDLE, `pc_jmp_en`=1, `pc_jmp_target`=`ENTRY`, `issue_valid`=0, `busy`=0, `done`=0, `err`=0, `issue_cnt`=0, loop inactive, `rem`=0.
- All outputs derive from registered state plus the same-cycle `ctl_*`, `pc` and `stall` inputs. There are no combinational paths from `start` to outputs.
- `start` high at edge t: RUN from t. The first `issue_valid` is in the cycle after edge t, with `pc`=ENTRY.
- A jump decided in cycle c takes effect with `pc`=target in cycle c+1. There is no bubble.
- HALT seen in cycle h: `done` is high in cycle h+`PIPE_DEPTH`+1, and IDLE starts in the following cycle.
- **Reset mid-operation:** all state returns to reset values immediately. `done` is not emitted.
- **`stall` and HALT together:** the HALT is not acted on until `stall`=0.

## Structure
- **Package `seq_pkg`:** `ctl_op` encodings (OP_NOP, OP_JMP, OP_LOOP_END, OP_HALT) and the state enumeration.
- **Sub-module `loop_unit`:** `rem` register plus active flag. Inputs are evaluate-enable, `ctl_count`, and clear. Output is `taken`.
- The top level holds the FSM, the drain counter, `issue_cnt` and `err`.

## Test plan
- **Straight line:** program of NOP×4 then HALT at address 4, `start` pulse, `PIPE_DEPTH`=3. Expect `pc` sequence 0,1,2,3,4; `issue_cnt`=4; `done` 4 cycles after HALT; `err`=0.
- **Jump:** JMP at address 1 with target 5, HALT at address 6. Expect `pc` sequence 0,1,5,6 and `issue_cnt`=3.
- **Loop:** LOOP_END at address 3 with target 1 and count 3, HALT at address 4. Expect body addresses 1..3 issued three times, `issue_cnt`=10. Repeat with count 0 and count 1: `issue_cnt`=4.
- **Stall:** assert `stall` for 3 cycles at `pc`=2, including across a JMP. Expect PC held, `issue_valid`=0, the jump taken after release, and `issue_cnt` unchanged during the stall.
- **End of memory:** all-NOP ROM. Expect `pc` to reach 63 and issue, `err`=1, then the drain and `done` sequence; `pc` never returns to 0 during the run.
- **Reset mid-run:** drop `rst` during RUN inside an active loop. Expect all reset values immediately and no `done`. A subsequent `start` must execute the full loop count from scratch.
